// File: rtl/fifo_rd_arbiter_pkg.sv
// Shared definitions for the read-side FIFO controller: FSM encoding and
// default geometry.
package fifo_ctrl_pkg;
  localparam int ADDRSIZE_DEF = 4;
  localparam int DATASIZE_DEF = 8;
  localparam int BURST_DEF    = 4;
  localparam int NUM_CONS     = 2;
  // Wide enough for BURST up to 15
  localparam int BCNT_W       = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;
endpackage

// File: rtl/fifo_rd_arbiter_if.sv
// Read-domain bus between the arbiter and its FIFO/consumers.
interface fifo_rd_arbiter_if #(
  parameter int ADDRSIZE = fifo_ctrl_pkg::ADDRSIZE_DEF,
  parameter int DATASIZE = fifo_ctrl_pkg::DATASIZE_DEF
);
  logic [ADDRSIZE:0]   i_wptr_gray;
  logic [ADDRSIZE:0]   o_rptr_gray;
  logic [ADDRSIZE-1:0] o_raddr;
  logic                o_mem_ren;
  logic [DATASIZE-1:0] i_mem_rdata;
  logic [1:0]          i_req;
  logic [1:0]          o_rvalid;
  logic [DATASIZE-1:0] o_rdata;
  logic                o_empty;
  logic [ADDRSIZE:0]   o_level;

  modport slave (
    input  i_wptr_gray, i_mem_rdata, i_req,
    output o_rptr_gray, o_raddr, o_mem_ren, o_rvalid, o_rdata, o_empty, o_level
  );

  modport master (
    output i_wptr_gray, i_mem_rdata, i_req,
    input  o_rptr_gray, o_raddr, o_mem_ren, o_rvalid, o_rdata, o_empty, o_level
  );
endinterface

// File: rtl/fifo_rd_arbiter_gray2bin.sv
// Combinational Gray-to-binary conversion of a FIFO pointer.
module gray2bin #(
  parameter int ADDRSIZE = 4
) (
  input  logic [ADDRSIZE:0] gray_i,
  output logic [ADDRSIZE:0] bin_o
);
  // Each binary bit is the XOR of all Gray bits at and above it
  for (genvar i = 0; i <= ADDRSIZE; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[ADDRSIZE:i];
  end
endmodule

// File: rtl/fifo_rd_arbiter.sv
// FIFO read-side controller: empty/level tracking plus a two-consumer
// round-robin arbiter that grants bursts of up to BURST reads.
module fifo_rd_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int BURST    = BURST_DEF
) (
  input  logic               des_clk,
  input  logic               des_rst,
  fifo_rd_arbiter_if.slave   bus
);
  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0]       wbin;
  logic [PW-1:0]       rbin_q, rbin_d;
  logic [PW-1:0]       rptr_gray_q;
  logic [1:0]          rvalid_q;
  logic [BCNT_W-1:0]   burst_cnt_q;
  logic                owner_q, last_owner_q;
  state_e              state_q;
  logic                empty, ren, grant_owner, burst_done, owner_req;
  logic [DATASIZE-1:0] rdata;

  gray2bin #(.ADDRSIZE(ADDRSIZE)) u_g2b (
    .gray_i (bus.i_wptr_gray),
    .bin_o  (wbin)
  );

  assign empty     = (bus.i_wptr_gray == rptr_gray_q);
  assign owner_req = bus.i_req[owner_q];
  // Read strobe is combinational so a dropped request or a new write is seen the same cycle
  assign ren       = !des_rst && (state_q == SERVE) && owner_req && !empty;
  assign rbin_d    = rbin_q + {{ADDRSIZE{1'b0}}, ren};
  assign burst_done  = ren && ((burst_cnt_q + 1'b1) == BCNT_W'(BURST));
  assign grant_owner = bus.i_req[~last_owner_q] ? ~last_owner_q : last_owner_q;

  always_ff @(posedge des_clk) begin
    if (des_rst) begin
      rbin_q       <= '0;
      rptr_gray_q  <= '0;
      rvalid_q     <= '0;
      burst_cnt_q  <= '0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      state_q      <= IDLE;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rbin_d ^ (rbin_d >> 1);
      rvalid_q    <= {ren & owner_q, ren & ~owner_q};
      case (state_q)
        IDLE: begin
          if (!empty && (|bus.i_req)) begin
            state_q     <= SERVE;
            owner_q     <= grant_owner;
            burst_cnt_q <= '0;
          end
        end
        SERVE: begin
          if (ren) burst_cnt_q <= burst_cnt_q + 1'b1;
          if (!owner_req || empty || burst_done) begin
            state_q      <= IDLE;
            last_owner_q <= owner_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata           = bus.i_mem_rdata;
  assign bus.o_rdata     = rdata;
  assign bus.o_rptr_gray = rptr_gray_q;
  assign bus.o_raddr     = rbin_q[ADDRSIZE-1:0];
  assign bus.o_mem_ren   = ren;
  assign bus.o_rvalid    = rvalid_q;
  assign bus.o_empty     = empty;
  assign bus.o_level     = wbin - rbin_q;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter with a synchronous-RAM model.
module tb_fifo_rd_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int BURST = 4;

  logic des_clk = 1'b0;
  logic des_rst;
  int   pass_cnt = 0;
  int   check_cnt = 0;

  fifo_rd_arbiter_if #(.ADDRSIZE(AW), .DATASIZE(DW)) bus ();

  fifo_rd_arbiter #(.ADDRSIZE(AW), .DATASIZE(DW), .BURST(BURST)) dut (
    .des_clk (des_clk),
    .des_rst (des_rst),
    .bus     (bus.slave)
  );

  always #5 des_clk = ~des_clk;

  function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  always @(posedge des_clk) if (bus.o_mem_ren) bus.i_mem_rdata <= memval(bus.o_raddr);

  task automatic cyc();
    @(posedge des_clk); #1;
  endtask

  task automatic do_reset();
    des_rst = 1'b1; cyc(); des_rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc(); cyc(); #1;
    check_cnt++; if (bus.o_rptr_gray !== 5'b0) $display("FAIL reset_rptr: got %b exp 00000", bus.o_rptr_gray); else pass_cnt++;
    check_cnt++; if (bus.o_rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b exp 00", bus.o_rvalid); else pass_cnt++;
    check_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", bus.o_empty); else pass_cnt++;
    check_cnt++; if (bus.o_level !== 5'd0) $display("FAIL reset_level: got %0d exp 0", bus.o_level); else pass_cnt++;
    bus.i_wptr_gray = 5'b00101; bus.i_req = 2'b11; #1;
    check_cnt++; if (bus.o_level !== 5'd6) $display("FAIL reset_level_follow: got %0d exp 6", bus.o_level); else pass_cnt++;
    check_cnt++; if (bus.o_empty !== 1'b0) $display("FAIL reset_empty_follow: got %b exp 0", bus.o_empty); else pass_cnt++;
    check_cnt++; if (bus.o_mem_ren !== 1'b0) $display("FAIL reset_no_read: got %b exp 0", bus.o_mem_ren); else pass_cnt++;
    cyc();
    bus.i_wptr_gray = 5'b0; bus.i_req = 2'b00; des_rst = 1'b0;
  endtask

  task automatic test_empty();
    bus.i_req = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_cnt++; if (bus.o_mem_ren !== 1'b0) $display("FAIL empty_ren c%0d: got %b exp 0", k, bus.o_mem_ren); else pass_cnt++;
      check_cnt++; if (bus.o_rvalid !== 2'b00) $display("FAIL empty_rvalid c%0d: got %b exp 00", k, bus.o_rvalid); else pass_cnt++;
      check_cnt++; if (bus.o_empty !== 1'b1 || bus.o_level !== 5'd0)
        $display("FAIL empty_flags c%0d: got empty=%b level=%0d exp 1/0", k, bus.o_empty, bus.o_level); else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_burst();
    logic           exp_ren  [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    logic [AW-1:0]  exp_addr [10] = '{0, 0, 1, 2, 3, 0, 4, 5, 0, 0};
    logic [1:0]     exp_rv   [10] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    bus.i_wptr_gray = 5'b00101; bus.i_req = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1;
      check_cnt++; if (bus.o_mem_ren !== exp_ren[k]) $display("FAIL burst_ren c%0d: got %b exp %b", k, bus.o_mem_ren, exp_ren[k]); else pass_cnt++;
      if (exp_ren[k]) begin
        check_cnt++; if (bus.o_raddr !== exp_addr[k]) $display("FAIL burst_addr c%0d: got %0d exp %0d", k, bus.o_raddr, exp_addr[k]); else pass_cnt++;
      end
      check_cnt++; if (bus.o_rvalid !== exp_rv[k]) $display("FAIL burst_rvalid c%0d: got %b exp %b", k, bus.o_rvalid, exp_rv[k]); else pass_cnt++;
      if (exp_rv[k] != 2'b00) begin
        check_cnt++; if (bus.o_rdata !== memval(exp_addr[k-1])) $display("FAIL burst_rdata c%0d: got %h exp %h", k, bus.o_rdata, memval(exp_addr[k-1])); else pass_cnt++;
      end
      if (k == 8) begin
        check_cnt++; if (bus.o_empty !== 1'b1 || bus.o_level !== 5'd0)
          $display("FAIL burst_drained: got empty=%b level=%0d exp 1/0", bus.o_empty, bus.o_level); else pass_cnt++;
      end
      cyc();
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    logic [AW:0]   exp_g [4] = '{5'b10001, 5'b10000, 5'b00000, 5'b00001};
    logic [AW-1:0] got_a [4];
    logic [AW:0]   got_g [4];
    int  n = 0;
    bit  done = 1'b0;
    // Advance the read pointer to 30 by draining a 24-word fill
    bus.i_wptr_gray = 5'b10001; bus.i_req = 2'b01;
    for (int k = 0; k < 60 && !done; k++) begin
      #1;
      if (bus.o_empty) done = 1'b1; else cyc();
    end
    check_cnt++; if (!done) $display("FAIL wrap_drain_timeout: got empty=%b exp 1", bus.o_empty); else pass_cnt++;
    cyc(); cyc(); #1;
    check_cnt++; if (bus.o_rptr_gray !== 5'b10001) $display("FAIL wrap_preload_rptr: got %b exp 10001", bus.o_rptr_gray); else pass_cnt++;
    bus.i_wptr_gray = 5'b00011; #1;
    check_cnt++; if (bus.o_level !== 5'd4) $display("FAIL wrap_level: got %0d exp 4", bus.o_level); else pass_cnt++;
    for (int k = 0; k < 8; k++) begin
      if (bus.o_mem_ren) begin
        if (n < 4) begin got_a[n] = bus.o_raddr; got_g[n] = bus.o_rptr_gray; end
        n++;
      end
      cyc(); #1;
    end
    check_cnt++; if (n != 4) $display("FAIL wrap_read_count: got %0d exp 4", n); else pass_cnt++;
    for (int i = 0; i < 4 && i < n; i++) begin
      check_cnt++; if (got_a[i] !== exp_a[i]) $display("FAIL wrap_addr%0d: got %0d exp %0d", i, got_a[i], exp_a[i]); else pass_cnt++;
      check_cnt++; if (got_g[i] !== exp_g[i]) $display("FAIL wrap_gray%0d: got %b exp %b", i, got_g[i], exp_g[i]); else pass_cnt++;
    end
    check_cnt++; if (bus.o_empty !== 1'b1) $display("FAIL wrap_empty: got %b exp 1", bus.o_empty); else pass_cnt++;
    check_cnt++; if (bus.o_rptr_gray !== 5'b00011) $display("FAIL wrap_final_rptr: got %b exp 00011", bus.o_rptr_gray); else pass_cnt++;
    cyc();
  endtask

  task automatic test_drop();
    do_reset();
    bus.i_wptr_gray = 5'b01100; bus.i_req = 2'b11; #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b0) $display("FAIL drop_idle0: got %b exp 0", bus.o_mem_ren); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b1 || bus.o_raddr !== 4'd0) $display("FAIL drop_read0: got ren=%b addr=%0d exp 1/0", bus.o_mem_ren, bus.o_raddr); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b1 || bus.o_raddr !== 4'd1) $display("FAIL drop_read1: got ren=%b addr=%0d exp 1/1", bus.o_mem_ren, bus.o_raddr); else pass_cnt++;
    cyc(); bus.i_req = 2'b10; #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b0) $display("FAIL drop_suppressed: got %b exp 0", bus.o_mem_ren); else pass_cnt++;
    check_cnt++; if (bus.o_level !== 5'd6) $display("FAIL drop_level: got %0d exp 6", bus.o_level); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b0) $display("FAIL drop_rearb_idle: got %b exp 0", bus.o_mem_ren); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b1 || bus.o_raddr !== 4'd2) $display("FAIL drop_cons1_read: got ren=%b addr=%0d exp 1/2", bus.o_mem_ren, bus.o_raddr); else pass_cnt++;
    cyc(); bus.i_req = 2'b00; #1;
    check_cnt++; if (bus.o_rvalid !== 2'b10) $display("FAIL drop_cons1_rvalid: got %b exp 10", bus.o_rvalid); else pass_cnt++;
    check_cnt++; if (bus.o_rdata !== memval(4'd2)) $display("FAIL drop_cons1_rdata: got %h exp %h", bus.o_rdata, memval(4'd2)); else pass_cnt++;
    cyc();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.i_wptr_gray = 5'b01100; bus.i_req = 2'b01;
    cyc(); cyc(); cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b1 || bus.o_raddr !== 4'd2) $display("FAIL rstmid_pre: got ren=%b addr=%0d exp 1/2", bus.o_mem_ren, bus.o_raddr); else pass_cnt++;
    cyc(); des_rst = 1'b1; #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b0) $display("FAIL rstmid_no_read: got %b exp 0", bus.o_mem_ren); else pass_cnt++;
    cyc(); des_rst = 1'b0; bus.i_req = 2'b11; #1;
    check_cnt++; if (bus.o_rptr_gray !== 5'b0 || bus.o_raddr !== 4'd0) $display("FAIL rstmid_ptr: got gray=%b addr=%0d exp 00000/0", bus.o_rptr_gray, bus.o_raddr); else pass_cnt++;
    check_cnt++; if (bus.o_rvalid !== 2'b00) $display("FAIL rstmid_rvalid: got %b exp 00", bus.o_rvalid); else pass_cnt++;
    check_cnt++; if (bus.o_mem_ren !== 1'b0 || bus.o_level !== 5'd8) $display("FAIL rstmid_idle: got ren=%b level=%0d exp 0/8", bus.o_mem_ren, bus.o_level); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b1 || bus.o_raddr !== 4'd0) $display("FAIL rstmid_regrant: got ren=%b addr=%0d exp 1/0", bus.o_mem_ren, bus.o_raddr); else pass_cnt++;
    cyc(); bus.i_req = 2'b00; #1;
    check_cnt++; if (bus.o_rvalid !== 2'b01) $display("FAIL rstmid_owner0: got %b exp 01", bus.o_rvalid); else pass_cnt++;
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    bus.i_wptr_gray = 5'b00001; bus.i_req = 2'b10; #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b0 || bus.o_level !== 5'd1) $display("FAIL single_idle: got ren=%b level=%0d exp 0/1", bus.o_mem_ren, bus.o_level); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b1 || bus.o_raddr !== 4'd0) $display("FAIL single_read: got ren=%b addr=%0d exp 1/0", bus.o_mem_ren, bus.o_raddr); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_rvalid !== 2'b10) $display("FAIL single_rvalid: got %b exp 10", bus.o_rvalid); else pass_cnt++;
    check_cnt++; if (bus.o_empty !== 1'b1 || bus.o_mem_ren !== 1'b0) $display("FAIL single_empty: got empty=%b ren=%b exp 1/0", bus.o_empty, bus.o_mem_ren); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_rvalid !== 2'b00 || bus.o_mem_ren !== 1'b0) $display("FAIL single_quiet: got rvalid=%b ren=%b exp 00/0", bus.o_rvalid, bus.o_mem_ren); else pass_cnt++;
    // Two more words with both requesting: consumer 0 must win since consumer 1 was last
    bus.i_wptr_gray = 5'b00010; bus.i_req = 2'b11; #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b0 || bus.o_level !== 5'd2) $display("FAIL single_rearb: got ren=%b level=%0d exp 0/2", bus.o_mem_ren, bus.o_level); else pass_cnt++;
    cyc(); #1;
    check_cnt++; if (bus.o_mem_ren !== 1'b1 || bus.o_raddr !== 4'd1) $display("FAIL single_next_read: got ren=%b addr=%0d exp 1/1", bus.o_mem_ren, bus.o_raddr); else pass_cnt++;
    cyc(); bus.i_req = 2'b00; #1;
    check_cnt++; if (bus.o_rvalid !== 2'b01) $display("FAIL single_last_owner: got %b exp 01", bus.o_rvalid); else pass_cnt++;
    cyc();
  endtask

  initial begin
    des_rst = 1'b1;
    bus.i_req = 2'b00;
    bus.i_wptr_gray = '0;
    test_reset();
    test_empty();
    test_burst();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_single();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
